// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, valid/ready handshake with backpressure.
module pipelined_cpa #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_reg;

  // Subtraction is a + ~b + ~borrow, so a borrow-in of 0 becomes a carry-in of 1.
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub ? ~c_in : c_in;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int REM  = WIDTH - gi * CHUNK;
    localparam int DONE = (gi + 1) * CHUNK;

    logic [REM-1:0]  a_in;
    logic [REM-1:0]  b_in;
    logic            carry_in;
    logic            valid_in;
    logic [CHUNK:0]  chunk_sum;
    logic [DONE-1:0] sum_next;
    logic            valid_reg;
    logic            carry_reg;
    logic [DONE-1:0] sum_reg;

    if (gi == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign carry_in = cin_eff;
      assign valid_in = in_valid;
      assign sum_next = chunk_sum[CHUNK-1:0];
    end else begin : g_body
      assign a_in     = g_stage[gi-1].g_skew.a_skew_reg;
      assign b_in     = g_stage[gi-1].g_skew.b_skew_reg;
      assign carry_in = g_stage[gi-1].carry_reg;
      assign valid_in = g_stage[gi-1].valid_reg;
      assign sum_next = {chunk_sum[CHUNK-1:0], g_stage[gi-1].sum_reg};
    end

    assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_in};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        sum_reg   <= '0;
      end else if (advance) begin
        valid_reg <= valid_in;
        carry_reg <= chunk_sum[CHUNK];
        sum_reg   <= sum_next;
      end
    end

    if (gi < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] a_skew_reg;
      logic [REM-CHUNK-1:0] b_skew_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_skew_reg <= '0;
          b_skew_reg <= '0;
        end else if (advance) begin
          a_skew_reg <= a_in[REM-1:CHUNK];
          b_skew_reg <= b_in[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg <= chunk_sum[CHUNK]
                   ^ (chunk_sum[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1]);
        end
      end
    end
  end

  assign s         = g_stage[STAGES-1].sum_reg;
  assign c_out     = g_stage[STAGES-1].carry_reg;
  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign ovf       = ovf_reg;

endmodule

// File: doc/pipelined_cpa.md
Name: pipelined_cpa

Overview:
- Parametrised, pipelined successor to the 16-bit carry-propagate adder built from 4-bit ripple slices.
- Splits a WIDTH-bit add or subtract into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle behind a valid/ready handshake and supports output backpressure.
- Used wherever a wide adder would otherwise break timing, for example accumulators and address generators.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per pipeline stage.
- STAGES, WIDTH/CHUNK: derived local value, not overridable; equals the pipeline latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a, b, c_in and sub carry a valid operation.
- in_ready  out  1  block accepts an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0: s = a + b + c_in; 1: s = a - b - c_in.
- out_valid  out  1  s, c_out and ovf hold a completed result.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  sum or difference modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits cleared. out_valid = 0, s = 0, c_out = 0, ovf = 0. in_ready = 1 once reset has taken effect. Operand and carry registers are cleared to 0.
- Operand preprocessing at acceptance:
  - b_eff = sub ? ~b : b
  - cin_eff = sub ? ~c_in : c_in
  - This gives a + ~b + 1 for sub with c_in = 0.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds chunk k of a and b_eff plus the registered carry from stage k-1. Stage 0 uses cin_eff.
  - Stage k registers its sum chunk, its carry out, and the still-unprocessed upper chunks of a and b_eff (skew registers).
  - Lower sum chunks are delayed so all chunks of one result appear together at the last stage.
- Latency: the result of an operation accepted in cycle t is visible with out_valid = 1 in cycle t + STAGES, absent stalls.
- Advance condition: advance = !out_valid || out_ready.
  - This is a global enable: every stage register, including each stage valid bit, loads only when advance = 1.
  - in_ready = advance. This is combinational from out_ready and the out_valid register.
- Acceptance: occurs when in_valid && in_ready. If in_valid = 0 while advancing, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed. Throughput is one result per cycle while out_ready stays high.
- Stall: while out_valid = 1 and out_ready = 0, all pipeline contents, s, c_out, ovf and out_valid hold exactly. in_ready = 0, so any input presented is ignored.
- Holding rule: s, c_out and ovf change only on cycles where advance = 1. Their values while out_valid = 0 are don't-care but deterministic (the last loaded value).
- ovf is computed in the final stage: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Mode isolation: sub affects only the operation it accompanies. Operations of different modes may be interleaved back-to-back.
- Reset mid-operation: all in-flight operations are discarded, with no partial result emitted. The first result after reset belongs to the first operation accepted after rst_n rises.
- Boundary: CHUNK = WIDTH gives STAGES = 1, a single registered adder with the same handshake.

Test Plan (WIDTH = 16, CHUNK = 4, so latency is 4):
1. Reset, then one add with a = 0xFFFF, b = 0x0001, c_in = 0, out_ready = 1 -> exactly 4 cycles later out_valid = 1 for one cycle; s = 0x0000, c_out = 1, ovf = 0.
2. Subtract with a = 0x8000, b = 0x0001, sub = 1, c_in = 0 -> s = 0x7FFF, c_out = 1, ovf = 1. Also a = 0x0000, b = 0x0001, sub = 1 -> s = 0xFFFF, c_out = 0, ovf = 0.
3. Back-to-back stream of 100 random operations with mixed sub and c_in, out_ready = 1 -> one result per cycle, in order, every s, c_out and ovf matching the reference model; in_ready stays 1.
4. Stream with out_ready = 0 for 3 cycles while out_valid = 1 -> in_ready = 0, and outputs and the pipeline stay frozen. Release -> all results arrive in order with none lost or duplicated.
5. Assert rst_n = 0 for 1 cycle while 3 operations are in flight -> out_valid stays 0 and none of the 3 ever appear. A new add 0x1234 + 0x4321 gives s = 0x5555, c_out = 0, 4 cycles after acceptance.
6. Repeat scenarios 1 and 3 with WIDTH = 32, CHUNK = 8 and with WIDTH = 8, CHUNK = 8 -> latency 4 and 1 respectively; results match the model.
